// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial front end.
package serializer_pkg;

  typedef enum logic {S_IDLE, S_SHIFT} ser_state_e;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Accepts WIDTH-bit words over valid/ready and shifts them out one bit per clock,
// with a one-word hold register so consecutive words stream without a gap.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hold_full, hold_full_n;
  logic             accept;
  logic [WIDTH-1:0] sh_shifted;

  // Ready comes straight from a register, so upstream never sees a comb path.
  assign in_ready   = ~hold_full;
  assign accept     = in_valid & in_ready;
  assign sh_shifted = MSB_FIRST ? (sh << 1) : (sh >> 1);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n     = state;
    sh_n        = sh;
    cnt_n       = cnt;
    hold_n      = hold;
    hold_full_n = hold_full;
    case (state)
      S_IDLE: begin
        if (accept) begin
          sh_n    = in_data;
          cnt_n   = '0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == LAST) begin
          if (hold_full) begin
            sh_n        = hold;
            hold_full_n = 1'b0;
            cnt_n       = '0;
          end else if (accept) begin
            sh_n  = in_data;
            cnt_n = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          sh_n  = sh_shifted;
          cnt_n = cnt + CW'(1);
          if (accept) begin
            hold_n      = in_data;
            hold_full_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
    end
  end

  assign bit_valid = (state == S_SHIFT);
  assign word_done = (state == S_SHIFT) && (cnt == LAST);
  assign busy      = (state == S_SHIFT) || hold_full;
  assign bit_out   = (state != S_SHIFT) ? IDLE_LEVEL
                   : (MSB_FIRST ? sh[WIDTH-1] : sh[0]);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a word/bit-index reference model.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;

  logic m_ready, m_bit, m_valid, m_done, m_busy;
  logic l_ready, l_bit, l_valid, l_done, l_busy;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_ready), .bit_out(m_bit), .bit_valid(m_valid),
    .word_done(m_done), .busy(m_busy)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_ready), .bit_out(l_bit), .bit_valid(l_valid),
    .word_done(l_done), .busy(l_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: current word plus bits still to present, and an optional held word.
  logic [W-1:0] cur_word = '0;
  int           cur_left = 0;
  logic [W-1:0] hold_word = '0;
  bit           hold_v = 1'b0;
  bit           last_acc = 1'b0;

  function automatic bit exp_valid(); return cur_left > 0; endfunction
  function automatic bit exp_ready(); return !hold_v; endfunction
  function automatic bit exp_busy();  return (cur_left > 0) || hold_v; endfunction

  task automatic model_edge();
    bit acc;
    acc = reset && in_valid && !hold_v;
    last_acc = acc;
    if (!reset) begin
      cur_left = 0;
      hold_v   = 1'b0;
    end else if (cur_left > 0) begin
      if (cur_left == 1) begin
        if (hold_v) begin
          cur_word = hold_word; cur_left = W; hold_v = 1'b0;
        end else if (acc) begin
          cur_word = in_data; cur_left = W;
        end else begin
          cur_left = 0;
        end
      end else begin
        cur_left--;
        if (acc) begin
          hold_word = in_data; hold_v = 1'b1;
        end
      end
    end else if (acc) begin
      cur_word = in_data; cur_left = W;
    end
  endtask

  logic [15:0] rec_m, rec_l;
  int          rec_n;

  task automatic rec_clear();
    rec_m = '0; rec_l = '0; rec_n = 0;
  endtask

  task automatic compare();
    bit v;
    logic eb_m, eb_l;
    v    = exp_valid();
    eb_m = v ? cur_word[cur_left-1] : 1'b0;
    eb_l = v ? cur_word[W-cur_left] : 1'b0;
    check("bit_valid_m", m_valid, v);
    check("bit_valid_l", l_valid, v);
    check("bit_out_m", m_bit, eb_m);
    check("bit_out_l", l_bit, eb_l);
    check("word_done", m_done, cur_left == 1);
    check("in_ready", m_ready, exp_ready());
    check("busy", m_busy, exp_busy());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (m_valid === 1'b1) begin
      rec_m = {rec_m[14:0], m_bit};
      rec_l = {rec_l[14:0], l_bit};
      rec_n++;
    end
  endtask

  task automatic offer_until_accept(input logic [W-1:0] w);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 40);
    check("accept_timeout", n >= 40 && !last_acc, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_busy() && n < 60) begin
      step();
      n++;
    end
    check("idle_timeout", exp_busy(), 0);
  endtask

  logic [W-1:0] txq[$];
  int           words_sent;

  initial begin
    // Reset held with a word on offer: nothing may be accepted.
    reset = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    step(); step();
    check("rst_bit_valid", m_valid, 0);
    check("rst_in_ready", m_ready, 1);
    reset = 1'b1; in_valid = 1'b0;
    rec_clear();
    repeat (4) step();
    check("rst_no_bits", rec_n, 0);

    // Single word, both bit orders.
    rec_clear();
    offer_until_accept(8'hDA);
    in_valid = 1'b0;
    wait_idle();
    check("da_msb", rec_m[7:0], 8'hDA);
    check("da_lsb", rec_l[7:0], 8'h5B);
    check("da_count", rec_n, 8);

    rec_clear();
    offer_until_accept(8'h01);
    in_valid = 1'b0;
    wait_idle();
    check("w01_lsb", rec_l[7:0], 8'h80);
    check("w01_msb", rec_m[7:0], 8'h01);

    // Back-to-back with the second word parked in hold.
    rec_clear();
    offer_until_accept(8'hB4);
    offer_until_accept(8'h3C);
    check("b2b_hold_ready", m_ready, 0);
    in_valid = 1'b0;
    wait_idle();
    check("b2b_stream", rec_m, 16'hB43C);
    check("b2b_count", rec_n, 16);

    // Accept exactly on the last-bit edge of the previous word.
    rec_clear();
    offer_until_accept(8'h00);
    in_valid = 1'b0;
    while (cur_left != 1 && rec_n < 20) step();
    check("lastbit_slot", m_done, 1);
    in_valid = 1'b1; in_data = 8'h81;
    step();
    check("lastbit_acc", last_acc, 1);
    in_valid = 1'b0;
    wait_idle();
    check("lastbit_stream", rec_m, 16'h0081);
    check("lastbit_count", rec_n, 16);

    // Reset mid-word with the hold register occupied.
    offer_until_accept(8'hB4);
    offer_until_accept(8'h3C);
    in_valid = 1'b0;
    step(); step();
    check("mid_hold_full", m_ready, 0);
    reset = 1'b0;
    step();
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_ready", m_ready, 1);
    check("mid_rst_busy", m_busy, 0);
    check("mid_rst_bit", m_bit, 0);
    reset = 1'b1;
    rec_clear();
    step(); step();
    offer_until_accept(8'hF0);
    in_valid = 1'b0;
    wait_idle();
    check("post_rst_stream", rec_m[7:0], 8'hF0);
    check("post_rst_count", rec_n, 8);

    // Random streaming with gaps and junk data while not ready.
    for (int i = 0; i < 40; i++) txq.push_back(W'($urandom));
    words_sent = 0;
    rec_clear();
    for (int c = 0; c < 3000 && (txq.size() > 0 || exp_busy()); c++) begin
      if (txq.size() > 0 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = exp_ready() ? txq[0] : W'($urandom);
      end else begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
      end
      step();
      if (last_acc) begin
        void'(txq.pop_front());
        words_sent++;
      end
    end
    in_valid = 1'b0;
    check("rand_drained", txq.size(), 0);
    check("rand_bits", rec_n, words_sent * W);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
